// File: rtl/accel_pkg.sv
// Shared definitions for the activation pipeline and its output writer.
package accel_pkg;

    // Defaults shared with the Tanh/Sigmoid/ReLU activation units.
    localparam int ACT_DATA_WIDTH = 11;
    localparam int ACT_SA_LENGTH  = 256;

    // Output writer control states.
    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DRAIN,
        DONE
    } writer_state_t;

    // Width of an index counting 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/act_vector_writer_beat_mux.sv
// Selects one BEAT_ELEMS-wide slice of the captured activation vector and
// packs it into a memory write word; element k lands at [k*DATA_WIDTH +: DATA_WIDTH].
module beat_mux
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int SA_LENGTH  = ACT_SA_LENGTH,
    parameter int BEAT_ELEMS = 16,
    localparam int BEATS     = SA_LENGTH / BEAT_ELEMS,
    localparam int BEAT_W    = idx_width(BEATS)
) (
    input  logic signed [DATA_WIDTH-1:0]         vec_i [SA_LENGTH],
    input  logic        [BEAT_W-1:0]             beat_i,
    output logic        [BEAT_ELEMS*DATA_WIDTH-1:0] beat_o
);

    logic [BEAT_ELEMS*DATA_WIDTH-1:0] beats [BEATS];

    // Pre-pack every beat with constant indices so the run-time select is a
    // single word-wide mux driven only by the beat counter.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar k = 0; k < BEAT_ELEMS; k++) begin : g_elem
            assign beats[b][k*DATA_WIDTH +: DATA_WIDTH] = vec_i[b*BEAT_ELEMS + k];
        end
    end

    assign beat_o = beats[beat_i];

endmodule

// File: rtl/act_vector_writer.sv
// Captures activation vectors one at a time and writes each as BEATS
// consecutive memory beats, for a job of num_vectors vectors per start.
module act_vector_writer
    import accel_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int SA_LENGTH  = ACT_SA_LENGTH,
    parameter int BEAT_ELEMS = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic        [ADDR_WIDTH-1:0]     base_addr,
    input  logic        [CNT_WIDTH-1:0]      num_vectors,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DATA_WIDTH-1:0]     in_data [SA_LENGTH],
    output logic                             wr_en,
    input  logic                             wr_ready,
    output logic        [ADDR_WIDTH-1:0]     wr_addr,
    output logic [BEAT_ELEMS*DATA_WIDTH-1:0] wr_data,
    output logic                             busy,
    output logic                             done
);

    localparam int BEATS  = SA_LENGTH / BEAT_ELEMS;
    localparam int BEAT_W = idx_width(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (SA_LENGTH % BEAT_ELEMS != 0) begin : g_bad_beat_split
        $error("act_vector_writer: SA_LENGTH must be a multiple of BEAT_ELEMS");
    end

    writer_state_t                state_q, state_d;
    logic        [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic        [BEAT_W-1:0]     beat_q,  beat_d;
    logic        [CNT_WIDTH-1:0]  vec_q,   vec_d;
    logic        [CNT_WIDTH-1:0]  num_q,   num_d;
    logic                         in_ready_q, wr_en_q, busy_q, done_q;
    logic signed [DATA_WIDTH-1:0] vec_buf_q [SA_LENGTH];
    logic                         capture;

    // A vector is taken only while the writer advertises ready.
    assign capture = in_ready_q & in_valid;

    // Next-state logic: job setup, vector accept, beat drain and completion.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        vec_d   = vec_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    num_d   = num_vectors;
                    vec_d   = '0;
                    state_d = (num_vectors == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (capture) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_en_q && wr_ready) begin
                    // Address wraps naturally at 2^ADDR_WIDTH.
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        vec_d   = vec_q + CNT_WIDTH'(1);
                        state_d = (vec_q == num_q - CNT_WIDTH'(1)) ? DONE : ACCEPT;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered control outputs; reset aborts any job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            vec_q      <= '0;
            num_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            vec_q      <= vec_d;
            num_q      <= num_d;
            in_ready_q <= (state_d == ACCEPT);
            wr_en_q    <= (state_d == DRAIN);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    // Vector buffer: pure data, loaded on handshake, no reset needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            vec_buf_q <= in_data;
        end
    end

    beat_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SA_LENGTH  (SA_LENGTH),
        .BEAT_ELEMS (BEAT_ELEMS)
    ) u_beat_mux (
        .vec_i  (vec_buf_q),
        .beat_i (beat_q),
        .beat_o (wr_data)
    );

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_act_vector_writer.sv
// Directed bench for act_vector_writer with a beat-list scoreboard.
module tb_act_vector_writer;

    localparam int DW    = 11;
    localparam int SA    = 8;
    localparam int BE    = 4;
    localparam int BEATS = SA / BE;
    localparam int AW    = 16;
    localparam int CW    = 16;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [BE*DW-1:0] data;
    } beat_t;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [CW-1:0]        num_vectors;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data [SA];
    logic                 wr_en;
    logic                 wr_ready;
    logic [AW-1:0]        wr_addr;
    logic [BE*DW-1:0]     wr_data;
    logic                 busy;
    logic                 done;

    act_vector_writer #(
        .DATA_WIDTH (DW),
        .SA_LENGTH  (SA),
        .BEAT_ELEMS (BE),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_vectors (num_vectors),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int rdy_cnt  = 0;

    logic signed [DW-1:0] vecs [8][SA];
    beat_t                exp_q [$];
    logic [AW-1:0]        acc_addr [$];
    logic [BE*DW-1:0]     acc_data [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Model: vector v, beat b goes to base + v*BEATS + b carrying elements
    // b*BE .. b*BE+BE-1 unchanged.
    task automatic build_exp(input logic [AW-1:0] base, input int n);
        beat_t e;
        for (int v = 0; v < n; v++) begin
            for (int b = 0; b < BEATS; b++) begin
                e.addr = AW'(int'(base) + v*BEATS + b);
                for (int k = 0; k < BE; k++) begin
                    e.data[k*DW +: DW] = vecs[v][b*BE + k];
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: every accepted beat against the model, stalls held stable.
    logic             stalled_prev = 1'b0;
    logic [AW-1:0]    prev_addr;
    logic [BE*DW-1:0] prev_data;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            beat_t e;
            if (done)     done_cnt++;
            if (in_ready) rdy_cnt++;
            chk("ready_and_write_exclusive", 64'(in_ready & wr_en), 64'(0));
            if (stalled_prev) begin
                chk("stall_wr_en",   64'(wr_en),   64'(1));
                chk("stall_wr_addr", 64'(wr_addr), 64'(prev_addr));
                chk("stall_wr_data", 64'(wr_data), 64'(prev_data));
            end
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(wr_addr), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", 64'(wr_addr), 64'(e.addr));
                    chk("beat_data", 64'(wr_data), 64'(e.data));
                end
                acc_addr.push_back(wr_addr);
                acc_data.push_back(wr_data);
            end
            stalled_prev = wr_en & ~wr_ready;
            prev_addr    = wr_addr;
            prev_data    = wr_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // One job: start, hold vectors valid, optional stall on the first beat,
    // optional ignored start pulse during drain; checks timing and counts.
    task automatic run_job(input logic [AW-1:0] base, input int n, input int stall,
                           input bit poke, output int cycles);
        int vi, cyc, stall_left, done0, rdy0, a0;
        bit pend, poked, fin;
        build_exp(base, n);
        done0 = done_cnt; rdy0 = rdy_cnt; a0 = acc_addr.size();
        vi = 0; cyc = 0; stall_left = stall; pend = 0; poked = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; base_addr = base; num_vectors = CW'(n); wr_ready = 1'b1;
        in_valid = (n > 0);
        if (n > 0) in_data = vecs[0];
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (pend) begin vi++; pend = 0; end
            if (done) begin
                fin = 1;
            end else begin
                in_valid = (vi < n);
                if (vi < n) in_data = vecs[vi];
                if (in_ready && in_valid) pend = 1;
                if (wr_en && acc_addr.size() == a0 && stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else begin
                    wr_ready = 1'b1;
                end
                if (poke && !poked && wr_en) begin
                    start = 1'b1; base_addr = 16'h0050; num_vectors = 16'd5; poked = 1;
                end
            end
        end
        cycles = cyc;
        chk("job_done_seen", 64'(fin), 64'(1));
        chk("busy_in_done", 64'(busy), 64'(1));
        chk("job_cycles", 64'(cyc), 64'(n*(1+BEATS) + stall + 1));
        in_valid = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("beats_missing", 64'(exp_q.size()), 64'(0));
        chk("beat_count", 64'(acc_addr.size() - a0), 64'(n*BEATS));
        chk("done_pulses", 64'(done_cnt - done0), 64'(1));
        chk("in_ready_cycles", 64'(rdy_cnt - rdy0), 64'(n));
    endtask

    task automatic set_basic_vec();
        vecs[0][0] = 11'sd1;  vecs[0][1] = 11'sd2;  vecs[0][2] = 11'sd3;  vecs[0][3] = 11'sd4;
        vecs[0][4] = -11'sd5; vecs[0][5] = -11'sd6; vecs[0][6] = -11'sd7; vecs[0][7] = -11'sd8;
    endtask

    initial begin
        int c1, c3, cx, a0, done0, w;
        logic [BE*DW-1:0] lit0, lit1;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_vectors = '0;
        in_valid = 1'b0; wr_ready = 1'b1;
        for (int e = 0; e < SA; e++) in_data[e] = '0;

        // Reset state.
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wr_en",    64'(wr_en),    64'(0));
        chk("rst_busy",     64'(busy),     64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_wr_addr",  64'(wr_addr),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        // 1. Basic job with hand-packed beats.
        set_basic_vec();
        lit0 = {11'h004, 11'h003, 11'h002, 11'h001};
        lit1 = {11'h7F8, 11'h7F9, 11'h7FA, 11'h7FB};
        a0 = acc_addr.size();
        run_job(16'h0010, 1, 0, 0, c1);
        chk("t1_addr0", 64'(acc_addr[a0]),   64'h10);
        chk("t1_data0", 64'(acc_data[a0]),   64'(lit0));
        chk("t1_addr1", 64'(acc_addr[a0+1]), 64'h11);
        chk("t1_data1", 64'(acc_data[a0+1]), 64'(lit1));

        // 2. Multi-vector job.
        for (int v = 0; v < 3; v++)
            for (int e = 0; e < SA; e++)
                vecs[v][e] = DW'(v*37 + e*113 - 500);
        a0 = acc_addr.size();
        run_job(16'h0100, 3, 0, 0, cx);
        for (int i = 0; i < 6; i++)
            chk("t2_addr_seq", 64'(acc_addr[a0+i]), 64'(16'h0100 + i));

        // 3. Backpressure on beat 0.
        set_basic_vec();
        run_job(16'h0010, 1, 3, 0, c3);
        chk("t3_stall_cost", 64'(c3 - c1), 64'(3));

        // 4A. Address wrap with extreme element values.
        vecs[0][0] = 11'sd1023; vecs[0][1] = -11'sd1024; vecs[0][2] = 11'sd0;   vecs[0][3] = -11'sd1;
        vecs[0][4] = 11'sd511;  vecs[0][5] = -11'sd512;  vecs[0][6] = 11'sd1;   vecs[0][7] = -11'sd2;
        a0 = acc_addr.size();
        run_job(16'hFFFF, 1, 0, 0, cx);
        chk("t4_addr_ffff", 64'(acc_addr[a0]),   64'hFFFF);
        chk("t4_addr_0000", 64'(acc_addr[a0+1]), 64'h0000);

        // 4B. Zero-length job: done in the cycle after the start cycle.
        run_job(16'h0077, 0, 0, 0, cx);

        // 5. Asynchronous reset mid-drain.
        set_basic_vec();
        build_exp(16'h0030, 1);
        a0 = acc_addr.size(); done0 = done_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0030; num_vectors = 16'd1;
        in_valid = 1'b1; in_data = vecs[0]; wr_ready = 1'b1;
        w = 0;
        while (acc_addr.size() == a0 && w < 50) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        chk("t5_pre_reset_wr_en", 64'(wr_en), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_wr_en",    64'(wr_en),    64'(0));
        chk("t5_async_busy",     64'(busy),     64'(0));
        chk("t5_async_in_ready", 64'(in_ready), 64'(0));
        chk("t5_async_wr_addr",  64'(wr_addr),  64'(0));
        exp_q.delete();
        in_valid = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt - done0), 64'(0));
        chk("t5_idle_busy", 64'(busy), 64'(0));
        for (int v = 0; v < 2; v++)
            for (int e = 0; e < SA; e++)
                vecs[v][e] = DW'(300 - v*250 - e*41);
        run_job(16'h0040, 2, 0, 0, cx);

        // 6. Start pulsed during drain is ignored.
        a0 = acc_addr.size();
        run_job(16'h0020, 2, 0, 1, cx);
        chk("t6_addr1", 64'(acc_addr[a0+1]), 64'h21);
        chk("t6_addr3", 64'(acc_addr[a0+3]), 64'h23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
